// File: rtl/vreg_pkg.sv
// Shared defaults, state encoding and lane-gating helper for the vector register bank.
package vreg_pkg;

  localparam int DEF_NREGS = 16;
  localparam int DEF_LANES = 8;
  localparam int DEF_XLEN  = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

  // vl above the lane count saturates before it is compared with the lane index.
  function automatic logic lane_active(input int unsigned idx, input int unsigned vl,
                                       input int unsigned lanes);
    int unsigned sat;
    sat = (vl > lanes) ? lanes : vl;
    return idx < sat;
  endfunction

endpackage

// File: rtl/vreg_clear_fsm.sv
// Clear sweep sequencer: walks every register once after reset or on request, then idles.
module vreg_clear_fsm
  import vreg_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr_start,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr,
  output logic          ready
);

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic          ready_q, ready_d;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ready_d = ready_q;
    case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          ptr_d   = '0;
          ready_d = 1'b0;
        end
      end
      CLEAR: begin
        if (ptr_q == AW'(NREGS - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
          ready_d = 1'b1;
        end else begin
          ptr_d = ptr_q + AW'(1);
        end
      end
      default: begin
        state_d = CLEAR;
        ptr_d   = '0;
        ready_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ready_q <= ready_d;
    end
  end

  assign clr_en   = (state_q == CLEAR);
  assign clr_addr = ptr_q;
  assign ready    = ready_q;

endmodule

// File: rtl/vreg_bank.sv
// Parametrised vector register file with lane masking, vl gating, busy scoreboard and clear sweep.
// Optional write-to-read forwarding is enabled by defining VREG_BYPASS_EN.
module vreg_bank
  import vreg_pkg::*;
#(
  parameter int NREGS = DEF_NREGS,
  parameter int LANES = DEF_LANES,
  parameter int XLEN  = DEF_XLEN,
  parameter int AW    = $clog2(NREGS),
  parameter int VLW   = $clog2(LANES + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [VLW-1:0]        vl,
  input  logic                  we,
  input  logic [AW-1:0]         wa,
  input  logic [LANES*XLEN-1:0] wd,
  input  logic [LANES-1:0]      wmask,
  input  logic [AW-1:0]         ra1,
  input  logic [AW-1:0]         ra2,
  output logic [LANES*XLEN-1:0] rd1,
  output logic [LANES*XLEN-1:0] rd2,
  input  logic                  sb_set,
  input  logic [AW-1:0]         sb_addr,
  output logic                  busy1,
  output logic                  busy2,
  input  logic                  clr_start,
  output logic                  ready
);

  logic [XLEN-1:0]  mem [NREGS][LANES];
  logic [NREGS-1:0] busy_q, busy_d;
  logic             clr_en;
  logic [AW-1:0]    clr_addr;
  logic             wr_go;
  logic [LANES-1:0] lane_on;
  logic [LANES-1:0] lane_wr;
  logic             fwd1, fwd2;

  vreg_clear_fsm #(.NREGS(NREGS), .AW(AW)) u_clear (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr_start(clr_start),
    .clr_en   (clr_en),
    .clr_addr (clr_addr),
    .ready    (ready)
  );

  assign wr_go = ready & we;

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign lane_on[gi] = lane_active(32'(gi), 32'(vl), 32'(LANES));
      assign lane_wr[gi] = wmask[gi] & lane_on[gi];
    end
  endgenerate

  // Storage is deliberately unreset; the sweep is what zeroes it.
  always_ff @(posedge clk) begin
    if (clr_en) begin
      for (int i = 0; i < LANES; i++) mem[clr_addr][i] <= '0;
    end else if (wr_go) begin
      for (int i = 0; i < LANES; i++)
        if (lane_wr[i]) mem[wa][i] <= wd[i*XLEN +: XLEN];
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (clr_en) begin
      busy_d[clr_addr] = 1'b0;
    end else begin
      if (wr_go)  busy_d[wa]      = 1'b0;
      if (sb_set) busy_d[sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

`ifdef VREG_BYPASS_EN
  assign fwd1 = wr_go & (ra1 == wa);
  assign fwd2 = wr_go & (ra2 == wa);
`else
  assign fwd1 = 1'b0;
  assign fwd2 = 1'b0;
`endif

  generate
    for (genvar gi = 0; gi < LANES; gi++) begin : g_rd
      assign rd1[gi*XLEN +: XLEN] = !lane_on[gi]          ? '0 :
                                    (fwd1 && lane_wr[gi]) ? wd[gi*XLEN +: XLEN] :
                                                            mem[ra1][gi];
      assign rd2[gi*XLEN +: XLEN] = !lane_on[gi]          ? '0 :
                                    (fwd2 && lane_wr[gi]) ? wd[gi*XLEN +: XLEN] :
                                                            mem[ra2][gi];
    end
  endgenerate

  // A forwarded write clears busy unless the same edge also re-marks it.
  assign busy1 = fwd1 ? (sb_set && sb_addr == ra1) : busy_q[ra1];
  assign busy2 = fwd2 ? (sb_set && sb_addr == ra2) : busy_q[ra2];

endmodule

// File: tb/tb_vreg_bank.sv
// Self-checking bench for vreg_bank: vector table with a read scoreboard plus sweep/scoreboard sequences.
module tb_vreg_bank;
  localparam int NR = 16;
  localparam int LN = 8;
  localparam int XL = 32;
  localparam int DW = LN * XL;
`ifdef VREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic [3:0]    vl;
  logic          we;
  logic [3:0]    wa;
  logic [DW-1:0] wd;
  logic [LN-1:0] wmask;
  logic [3:0]    ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic          sb_set;
  logic [3:0]    sb_addr;
  logic          busy1, busy2;
  logic          clr_start;
  logic          ready;

  always #5 clk = ~clk;

  vreg_bank #(.NREGS(NR), .LANES(LN), .XLEN(XL)) dut (
    .clk(clk), .reset_n(reset_n), .vl(vl), .we(we), .wa(wa), .wd(wd), .wmask(wmask),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .sb_set(sb_set), .sb_addr(sb_addr),
    .busy1(busy1), .busy2(busy2), .clr_start(clr_start), .ready(ready)
  );

  typedef struct {
    bit            wr;
    logic [3:0]    a;
    logic [3:0]    v;
    logic [LN-1:0] m;
    logic [DW-1:0] d;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [XL-1:0] shadow [NR][LN];
  logic [DW-1:0] exp_q [$];
  vec_t vecs [13];

  function automatic logic [DW-1:0] ramp(input logic [XL-1:0] base);
    logic [DW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*XL +: XL] = base + XL'(i);
    return r;
  endfunction

  function automatic logic [DW-1:0] fill(input logic [XL-1:0] val);
    logic [DW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*XL +: XL] = val;
    return r;
  endfunction

  function automatic int sat(input logic [3:0] v);
    return (int'(v) > LN) ? LN : int'(v);
  endfunction

  function automatic logic [DW-1:0] model_rd(input logic [3:0] a, input logic [3:0] v);
    logic [DW-1:0] r;
    for (int i = 0; i < LN; i++) r[i*XL +: XL] = (i < sat(v)) ? shadow[a][i] : '0;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] a, input logic [3:0] v, input logic [LN-1:0] m,
                          input logic [DW-1:0] d);
    we = 1'b1; wa = a; vl = v; wmask = m; wd = d;
    for (int i = 0; i < LN; i++)
      if (m[i] && i < sat(v)) shadow[a][i] = d[i*XL +: XL];
    tick();
    we = 1'b0;
  endtask

  task automatic push_read(input logic [3:0] a, input logic [3:0] v);
    ra1 = a; ra2 = a; vl = v;
    exp_q.push_back(model_rd(a, v));
  endtask

  task automatic pop_check(input string nm);
    logic [DW-1:0] e;
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard empty got=%h want=entry", nm, rd1);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_rd1"}, rd1, e);
      chk({nm, "_rd2"}, rd2, e);
    end
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!ready && n < 64) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_zero(input string nm);
    for (int r = 0; r < NR; r++) begin
      push_read(4'(r), 4'd8);
      pop_check($sformatf("%s_r%0d", nm, r));
      chk($sformatf("%s_busy%0d", nm, r), DW'(busy1), DW'(0));
    end
  endtask

  initial begin
    int n;
    logic [DW-1:0] e;
    reset_n = 1'b0; vl = '0; we = 1'b0; wa = '0; wd = '0; wmask = '0;
    ra1 = '0; ra2 = '0; sb_set = 1'b0; sb_addr = '0; clr_start = 1'b0;
    for (int r = 0; r < NR; r++) for (int i = 0; i < LN; i++) shadow[r][i] = '0;

    vecs[0]  = '{1'b1, 4'd3, 4'd8,  8'hFF, ramp(32'h1000)};
    vecs[1]  = '{1'b0, 4'd3, 4'd8,  8'h00, '0};
    vecs[2]  = '{1'b0, 4'd3, 4'd5,  8'h00, '0};
    vecs[3]  = '{1'b1, 4'd3, 4'd2,  8'h0F, fill(32'hDEADBEEF)};
    vecs[4]  = '{1'b0, 4'd3, 4'd8,  8'h00, '0};
    vecs[5]  = '{1'b1, 4'd4, 4'd9,  8'hFF, ramp(32'h2000)};
    vecs[6]  = '{1'b0, 4'd4, 4'd9,  8'h00, '0};
    vecs[7]  = '{1'b1, 4'd4, 4'd0,  8'hFF, fill(32'hFFFFFFFF)};
    vecs[8]  = '{1'b0, 4'd4, 4'd8,  8'h00, '0};
    vecs[9]  = '{1'b1, 4'd6, 4'd8,  8'hA5, ramp(32'h3000)};
    vecs[10] = '{1'b0, 4'd6, 4'd7,  8'h00, '0};
    vecs[11] = '{1'b0, 4'd3, 4'd15, 8'h00, '0};
    vecs[12] = '{1'b0, 4'd0, 4'd8,  8'h00, '0};

    // Reset held, then release and time the power-up sweep.
    tick(); tick(); tick();
    chk("rst_ready", DW'(ready), DW'(0));
    chk("rst_busy1", DW'(busy1), DW'(0));
    reset_n = 1'b1;
    wait_ready(n);
    $display("reset sweep done after %0d cycles", n);
    chk("rst_sweep_len", DW'(n), DW'(16));
    check_all_zero("init");

    for (int k = 0; k < 13; k++) begin
      if (vecs[k].wr) begin
        $display("vec %0d write a=%0d vl=%0d mask=%h", k, vecs[k].a, vecs[k].v, vecs[k].m);
        do_write(vecs[k].a, vecs[k].v, vecs[k].m, vecs[k].d);
      end else begin
        $display("vec %0d read a=%0d vl=%0d", k, vecs[k].a, vecs[k].v);
        push_read(vecs[k].a, vecs[k].v);
        pop_check($sformatf("vec%0d", k));
      end
    end

    // Scoreboard set, clear by write, and set-wins collision.
    $display("sb set addr 5");
    ra1 = 4'd5; ra2 = 4'd6; sb_set = 1'b1; sb_addr = 4'd5;
    #1 chk("sb_pre", DW'(busy1), DW'(0));
    tick(); sb_set = 1'b0;
    chk("sb_set_busy1", DW'(busy1), DW'(1));
    chk("sb_set_busy2", DW'(busy2), DW'(0));
    $display("sb clear by write addr 5");
    do_write(4'd5, 4'd0, 8'h00, '0);
    ra1 = 4'd5;
    #1 chk("sb_clr_busy1", DW'(busy1), DW'(0));
    $display("sb set and write same addr 5");
    sb_set = 1'b1; sb_addr = 4'd5; we = 1'b1; wa = 4'd5; wmask = 8'h00; vl = 4'd0;
    tick(); sb_set = 1'b0; we = 1'b0;
    chk("sb_setwins_busy1", DW'(busy1), DW'(1));

    // Requested sweep with a dropped mid-sweep write and an ignored second request.
    $display("clear sweep with mid-sweep write and restart request");
    clr_start = 1'b1;
    tick(); clr_start = 1'b0;
    chk("clr_ready_low", DW'(ready), DW'(0));
    n = 0;
    while (!ready && n < 64) begin
      if (n == 4) begin we = 1'b1; wa = 4'd2; wmask = 8'hFF; vl = 4'd8; wd = fill(32'hAAAA5555); end
      if (n == 7) clr_start = 1'b1;
      tick();
      we = 1'b0; clr_start = 1'b0;
      n++;
    end
    chk("clr_sweep_len", DW'(n), DW'(16));
    for (int r = 0; r < NR; r++) for (int i = 0; i < LN; i++) shadow[r][i] = '0;
    check_all_zero("clr");

    // Reset pulse mid-sweep restarts the full count.
    $display("reset pulse mid-sweep");
    do_write(4'd9, 4'd8, 8'hFF, ramp(32'h7000));
    clr_start = 1'b1;
    tick(); clr_start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset_n = 1'b0;
    #2 chk("midrst_ready", DW'(ready), DW'(0));
    tick();
    reset_n = 1'b1;
    wait_ready(n);
    chk("midrst_sweep_len", DW'(n), DW'(16));
    for (int r = 0; r < NR; r++) for (int i = 0; i < LN; i++) shadow[r][i] = '0;
    push_read(4'd9, 4'd8);
    pop_check("midrst_r9");

    // Same-cycle write/read on port 2.
    $display("write-read same cycle addr 7");
    do_write(4'd7, 4'd8, 8'hFF, ramp(32'h4000));
    sb_set = 1'b1; sb_addr = 4'd7;
    tick(); sb_set = 1'b0;
    ra1 = 4'd0; ra2 = 4'd7; vl = 4'd8; we = 1'b1; wa = 4'd7; wmask = 8'h01;
    wd = ramp(32'h55550000);
    e = ramp(32'h4000);
    if (BYP) e[XL-1:0] = 32'h55550000;
    #1 chk("byp_rd2_same", rd2, e);
    chk("byp_busy2_same", DW'(busy2), DW'(BYP ? 0 : 1));
    shadow[7][0] = 32'h55550000;
    for (int i = 1; i < LN; i++) shadow[7][i] = 32'h4000 + XL'(i);
    tick(); we = 1'b0;
    e = ramp(32'h4000);
    e[XL-1:0] = 32'h55550000;
    chk("byp_rd2_next", rd2, e);
    chk("byp_busy2_next", DW'(busy2), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
